// File: rtl/seg7_pkg.sv
// Shared types and constants for the eight-digit seven-segment scan driver.
// The blink field of the digit set exists only when SEG7_BLINK_EN is defined.
package seg7_pkg;

    // Segment patterns, bit order {dp,g,f,e,d,c,b,a}; dp is never set here.
    localparam logic [7:0] SEG_HEX [16] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
        8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
    };
    localparam logic [7:0] SEG_BLANK = 8'h00;
    localparam logic [7:0] SEG_DP    = 8'h80;

    typedef logic [1:0] phase_t;
    localparam phase_t PH_LAST = 2'd3;

    typedef struct packed {
        logic [31:0] digits;
        logic [7:0]  dp;
        logic [7:0]  blank;
`ifdef SEG7_BLINK_EN
        logic [7:0]  blink;
`endif
    } disp_set_t;

    function automatic logic [3:0] phase_onehot(input phase_t p);
        return 4'b0001 << p;
    endfunction

endpackage

// File: rtl/seg7_dec.sv
// Combinational hex-to-segment decoder with decimal point and blanking.
// A blanked digit is fully dark, decimal point included.
module seg7_dec
    import seg7_pkg::*;
(
    input  logic [3:0] i_val,
    input  logic       i_dp,
    input  logic       i_blank,
    output logic [7:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        if (!i_blank) begin
            o_seg = SEG_HEX[i_val] | (i_dp ? SEG_DP : SEG_BLANK);
        end
    end

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed driver for two 4-digit seven-segment banks with frame-aligned,
// double-buffered updates. Optional per-digit blinking under SEG7_BLINK_EN.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV     = 2,
    parameter int BLINK_FRAMES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] digit_val,
    input  logic [7:0]  dp_in,
    input  logic [7:0]  blank_in,
`ifdef SEG7_BLINK_EN
    input  logic [7:0]  blink_in,
`endif
    input  logic        upd,
    output logic        pend,
    output logic [7:0]  seg7_sel,
    output logic [7:0]  seg7,
    output logic [7:0]  seg7_l
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PCNT_LAST = PW'(SCAN_DIV - 1);

    generate
        if (SCAN_DIV < 2 || BLINK_FRAMES < 1) begin : g_param_check
            $error("seg7_scan: SCAN_DIV must be >= 2 and BLINK_FRAMES >= 1");
        end
    endgenerate

    logic [PW-1:0] r_pcnt;
    phase_t        r_ph;
    logic          r_pend;
    disp_set_t     r_pnd_set;
    disp_set_t     r_dsp_set;
    logic [7:0]    r_sel;
    logic [7:0]    r_seg_r;
    logic [7:0]    r_seg_l;

    logic          w_tick;
    logic          w_commit;
    phase_t        w_ph_next;
    disp_set_t     w_in_set;
    disp_set_t     w_dsp_next;
    logic [7:0]    w_blank_eff;
    logic [2:0]    w_idx_r;
    logic [2:0]    w_idx_l;
    logic [3:0]    w_val_r;
    logic [3:0]    w_val_l;
    logic [7:0]    w_seg_r;
    logic [7:0]    w_seg_l;
    logic [3:0]    w_onehot;

    assign w_tick    = (r_pcnt == PCNT_LAST);
    assign w_commit  = w_tick && (r_ph == PH_LAST);
    assign w_ph_next = phase_t'(r_ph + 2'd1);

    always_comb begin
        w_in_set        = '0;
        w_in_set.digits = digit_val;
        w_in_set.dp     = dp_in;
        w_in_set.blank  = blank_in;
`ifdef SEG7_BLINK_EN
        w_in_set.blink  = blink_in;
`endif
    end

    // An update landing on the commit tick bypasses the pending set entirely.
    always_comb begin
        w_dsp_next = r_dsp_set;
        if (w_commit) begin
            if (upd) begin
                w_dsp_next = w_in_set;
            end else if (r_pend) begin
                w_dsp_next = r_pnd_set;
            end
        end
    end

`ifdef SEG7_BLINK_EN
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FW-1:0] FCNT_LAST = FW'(BLINK_FRAMES - 1);

    logic [FW-1:0] r_fcnt;
    logic          r_blink_off;
    logic          w_blink_wrap;
    logic          w_blink_off_next;

    assign w_blink_wrap     = w_commit && (r_fcnt == FCNT_LAST);
    assign w_blink_off_next = r_blink_off ^ w_blink_wrap;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fcnt      <= '0;
            r_blink_off <= 1'b0;
        end else if (w_commit) begin
            r_fcnt      <= w_blink_wrap ? '0 : r_fcnt + 1'b1;
            r_blink_off <= w_blink_off_next;
        end
    end

    // The frame being started uses the blink state that takes effect on this tick.
    assign w_blank_eff = w_dsp_next.blank | (w_blink_off_next ? w_dsp_next.blink : 8'h00);
`else
    assign w_blank_eff = w_dsp_next.blank;
`endif

    assign w_idx_r  = {1'b0, w_ph_next};
    assign w_idx_l  = {1'b1, w_ph_next};
    assign w_val_r  = w_dsp_next.digits[{w_idx_r, 2'b00} +: 4];
    assign w_val_l  = w_dsp_next.digits[{w_idx_l, 2'b00} +: 4];
    assign w_onehot = phase_onehot(w_ph_next);

    seg7_dec u_dec_r (
        .i_val   (w_val_r),
        .i_dp    (w_dsp_next.dp[w_idx_r]),
        .i_blank (w_blank_eff[w_idx_r]),
        .o_seg   (w_seg_r)
    );

    seg7_dec u_dec_l (
        .i_val   (w_val_l),
        .i_dp    (w_dsp_next.dp[w_idx_l]),
        .i_blank (w_blank_eff[w_idx_l]),
        .o_seg   (w_seg_l)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pcnt           <= '0;
            r_ph             <= PH_LAST;
            r_pend           <= 1'b0;
            r_pnd_set        <= '0;
            r_pnd_set.blank  <= 8'hFF;
            r_dsp_set        <= '0;
            r_dsp_set.blank  <= 8'hFF;
            r_sel            <= 8'h00;
            r_seg_r          <= SEG_BLANK;
            r_seg_l          <= SEG_BLANK;
        end else begin
            r_pcnt    <= w_tick ? '0 : r_pcnt + 1'b1;
            r_dsp_set <= w_dsp_next;
            if (upd) begin
                r_pnd_set <= w_in_set;
            end
            if (w_commit) begin
                r_pend <= 1'b0;
            end else if (upd) begin
                r_pend <= 1'b1;
            end
            if (w_tick) begin
                r_ph    <= w_ph_next;
                r_sel   <= {w_onehot, w_onehot};
                r_seg_r <= w_seg_r;
                r_seg_l <= w_seg_l;
            end
        end
    end

    assign pend     = r_pend;
    assign seg7_sel = r_sel;
    assign seg7     = r_seg_r;
    assign seg7_l   = r_seg_l;

endmodule

// File: tb/tb_seg7_scan.sv
// Scoreboard bench for seg7_scan (SCAN_DIV=2): expected {pend,sel,seg7,seg7_l}
// per cycle are queued with the stimulus and checked by an independent monitor.
module tb_seg7_scan;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] digit_val;
    logic [7:0]  dp_in;
    logic [7:0]  blank_in;
`ifdef SEG7_BLINK_EN
    logic [7:0]  blink_in;
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif
    logic        upd;
    logic        pend;
    logic [7:0]  seg7_sel;
    logic [7:0]  seg7;
    logic [7:0]  seg7_l;

    seg7_scan #(.SCAN_DIV(2), .BLINK_FRAMES(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .digit_val (digit_val),
        .dp_in     (dp_in),
        .blank_in  (blank_in),
`ifdef SEG7_BLINK_EN
        .blink_in  (blink_in),
`endif
        .upd       (upd),
        .pend      (pend),
        .seg7_sel  (seg7_sel),
        .seg7      (seg7),
        .seg7_l    (seg7_l)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        string       tag;
        logic [24:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic void push(int c, string tag, logic p, logic [7:0] s, logic [7:0] r, logic [7:0] l);
        exp_t e;
        e.cyc = c;
        e.tag = tag;
        e.exp = {p, s, r, l};
        sb_q.push_back(e);
    endfunction

    // rv/lv hold {phase3,phase2,phase1,phase0}; pv bit k is pend in cycle c0+k.
    function automatic void push_frame(int c0, string tag, logic [7:0] pv, logic [31:0] rv, logic [31:0] lv);
        for (int k = 0; k < 8; k++) begin
            int p;
            logic [7:0] s;
            p = k / 2;
            s = 8'h11 << p;
            push(c0 + k, tag, pv[k], s, rv[8*p +: 8], lv[8*p +: 8]);
        end
    endfunction

    task automatic wait_neg(int c);
        @(negedge clk);
        while (cyc < c) @(negedge clk);
    endtask

    // Monitor: every sampled cycle pops whatever expectations are due.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
                e = sb_q.pop_front();
                n_cmp++;
                if (e.cyc != cyc || {pend, seg7_sel, seg7, seg7_l} !== e.exp) begin
                    n_bad++;
                    $display("FAIL %s cyc %0d (now %0d): got pend=%b sel=%h seg7=%h seg7_l=%h, want pend=%b sel=%h seg7=%h seg7_l=%h",
                             e.tag, e.cyc, cyc, pend, seg7_sel, seg7, seg7_l,
                             e.exp[24], e.exp[23:16], e.exp[15:8], e.exp[7:0]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    localparam logic [31:0] Z4  = 32'h0;
    localparam logic [31:0] O4  = 32'h3F3F3F3F;
    localparam logic [7:0]  B99 = BLINK ? 8'h00 : 8'h7F;
    localparam logic [7:0]  B107 = 8'h7F;
    localparam logic [7:0]  B115 = BLINK ? 8'h00 : 8'h7F;

    initial begin
        rst_n     = 1'b0;
        upd       = 1'b0;
        digit_val = '0;
        dp_in     = '0;
        blank_in  = '0;
`ifdef SEG7_BLINK_EN
        blink_in  = '0;
`endif
        // Reset and idle scan: all digits blank, sel rotates from edge 5.
        push(3, "reset", 1'b0, 8'h00, 8'h00, 8'h00);
        push(4, "pre_tick", 1'b0, 8'h00, 8'h00, 8'h00);
        push_frame(5,  "idle_f0", 8'h00, Z4, Z4);
        push_frame(13, "idle_f1", 8'h00, Z4, Z4);
        wait_neg(3);
        rst_n = 1'b1;

        // Single update, committed at the next frame start.
        push_frame(21, "upd_wait", 8'hFE, Z4, Z4);
        push_frame(29, "upd_show", 8'h00, 32'h4F5B063F, 32'h077D6D66);
        wait_neg(21);
        digit_val = 32'h7654_3210;
        upd       = 1'b1;
        wait_neg(22);
        upd       = 1'b0;

        // Two updates in one frame: last write wins.
        push_frame(37, "dbl_wait", 8'hFE, 32'h4F5B063F, 32'h077D6D66);
        push_frame(45, "dbl_show", 8'h00, 32'h3F3F3F77, O4);
        wait_neg(37);
        digit_val = 32'h0000_0001;
        upd       = 1'b1;
        wait_neg(38);
        upd       = 1'b0;
        wait_neg(40);
        digit_val = 32'h0000_000A;
        upd       = 1'b1;
        wait_neg(41);
        upd       = 1'b0;

        // Update on the commit tick goes straight to the display.
        push_frame(53, "bypass", 8'h00, 32'h3F3F3FFF, O4);
        wait_neg(52);
        digit_val = 32'h0000_0008;
        dp_in     = 8'h01;
        upd       = 1'b1;
        wait_neg(53);
        upd       = 1'b0;
        dp_in     = 8'h00;
        if (pend !== 1'b0) begin
            n_bad++;
            $display("FAIL bypass_pend: pend=%b after commit-tick update, want 0", pend);
        end

        // Right bank blanked, left bank shows 8.
        push_frame(61, "blank_wait", 8'hFE, 32'h3F3F3FFF, O4);
        push_frame(69, "blank_show", 8'h00, Z4, 32'h7F7F7F7F);
        wait_neg(61);
        digit_val = 32'h8888_8888;
        blank_in  = 8'h0F;
        upd       = 1'b1;
        wait_neg(62);
        upd       = 1'b0;
        blank_in  = 8'h00;
        if (pend !== 1'b1) begin
            n_bad++;
            $display("FAIL blank_pend: pend=%b after update, want 1", pend);
        end

        // Reset with pend=1 discards the pending data and restarts the scan.
        push(77, "rst_pre0", 1'b0, 8'h11, 8'h00, 8'h7F);
        push(78, "rst_pre1", 1'b1, 8'h11, 8'h00, 8'h7F);
        push(79, "rst_pre2", 1'b1, 8'h22, 8'h00, 8'h7F);
        push(80, "rst_mid0", 1'b0, 8'h00, 8'h00, 8'h00);
        push(81, "rst_mid1", 1'b0, 8'h00, 8'h00, 8'h00);
        push(82, "rst_rel", 1'b0, 8'h00, 8'h00, 8'h00);
        push_frame(83, "rst_f0", 8'h00, Z4, Z4);
        wait_neg(77);
        digit_val = 32'h1111_1111;
        upd       = 1'b1;
        wait_neg(78);
        upd       = 1'b0;
        wait_neg(79);
        rst_n     = 1'b0;
        wait_neg(81);
        rst_n     = 1'b1;

        // Blinking digit 0 (steady 8 when blink is not built in).
        push_frame(91,  "blink_wait", 8'hFE, Z4, Z4);
        push_frame(99,  "blink_f0", 8'h00, {24'h3F3F3F, B99},  O4);
        push_frame(107, "blink_f1", 8'h00, {24'h3F3F3F, B107}, O4);
        push_frame(115, "blink_f2", 8'h00, {24'h3F3F3F, B115}, O4);
        wait_neg(91);
        digit_val = 32'h0000_0008;
`ifdef SEG7_BLINK_EN
        blink_in  = 8'h01;
`endif
        upd       = 1'b1;
        wait_neg(92);
        upd       = 1'b0;

        wait_neg(125);
        while (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL %s cyc %0d: expectation never checked", e.tag, e.cyc);
        end
        if (n_cmp != 120) begin
            n_bad++;
            $display("FAIL count: %0d expectations compared, want 120", n_cmp);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        if (n_bad == 0) begin
            $display("PASS");
        end else begin
            $display("FAIL");
        end
        $finish;
    end

endmodule
